// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin sharing of one add/sub datapath among NREQ requesters,
// with a one-entry registered response. Build macro ADD_SUB_ARB_STATS_EN adds op/overflow counters.

module add_sub_module #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c_msb_in;

  assign b_eff    = b ^ {WIDTH{m}};
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, m};
  assign s        = sum[WIDTH-1:0];
  assign carry    = sum[WIDTH];
  // carry into the MSB is recovered from the MSB sum bit
  assign c_msb_in = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
  assign overflow = carry ^ c_msb_in;
endmodule

module add_sub_arbiter #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_M,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_carry,
  output logic                  rsp_overflow
`ifdef ADD_SUB_ARB_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           ovf_count
`endif
);
  typedef enum logic {IDLE, FULL} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   next_ptr;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   hi_id;
  logic [IDW-1:0]   lo_id;
  logic             hi_found;
  logic             lo_found;
  logic             grant_found;
  logic             can_issue;
  logic             issue;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_m;
  logic [WIDTH-1:0] dp_s;
  logic             dp_carry;
  logic             dp_overflow;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
  end

  assign can_issue = (state == IDLE) | rsp_ready;
  assign issue     = grant_found & can_issue & ~rst;
  assign next_ptr  = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    op_m = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        op_a = req_a[i*WIDTH +: WIDTH];
        op_b = req_b[i*WIDTH +: WIDTH];
        op_m = req_M[i];
      end
    end
  end

  add_sub_module #(.WIDTH(WIDTH)) u_datapath (
    .a        (op_a),
    .b        (op_b),
    .m        (op_m),
    .s        (dp_s),
    .carry    (dp_carry),
    .overflow (dp_overflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      rsp_id       <= '0;
      rsp_s        <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (issue) begin
      state        <= FULL;
      rr_ptr       <= next_ptr;
      rsp_id       <= grant_id;
      rsp_s        <= dp_s;
      rsp_carry    <= dp_carry;
      rsp_overflow <= dp_overflow;
    end else if (state == FULL && rsp_ready) begin
      state <= IDLE;
    end
  end

  assign rsp_valid = (state == FULL);

`ifdef ADD_SUB_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (issue) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (dp_overflow && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: directed literal cases plus randomized traffic checked every cycle
// against an arithmetic reference model.

module tb_add_sub_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_M;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_s;
  logic                  rsp_carry;
  logic                  rsp_overflow;
`ifdef ADD_SUB_ARB_STATS_EN
  logic [15:0]           op_count;
  logic [15:0]           ovf_count;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state
  bit              m_full;
  int              m_ptr;
  int              m_id, m_s, m_c, m_o;
  int              m_ops, m_ovfs;
  logic [NREQ-1:0] granted;

  add_sub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_M        (req_M),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_s        (rsp_s),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow)
`ifdef ADD_SUB_ARB_STATS_EN
    ,
    .op_count     (op_count),
    .ovf_count    (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input bit m);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_M[i]                = m;
  endtask

  // Compare process: checks DUT against the model, then advances the model to the next edge.
  always @(negedge clk) begin
    int  g, ia, ib, sa, sb, r, sr;
    bit  found;
    logic [NREQ-1:0] er;
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_s", rsp_s, 0);
      check("rst_rsp_carry", rsp_carry, 0);
      check("rst_rsp_overflow", rsp_overflow, 0);
      m_full = 0; m_ptr = 0; m_ops = 0; m_ovfs = 0; granted = '0;
    end else begin
      found = 0; g = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req_valid[(m_ptr + k) % NREQ]) begin
          g = (m_ptr + k) % NREQ;
          found = 1;
        end
      end
      er = (found && (!m_full || rsp_ready)) ? NREQ'(1 << g) : '0;
      check("req_ready", req_ready, er);
      check("rsp_valid", rsp_valid, m_full);
      if (m_full) begin
        check("rsp_id", rsp_id, m_id);
        check("rsp_s", rsp_s, m_s);
        check("rsp_carry", rsp_carry, m_c);
        check("rsp_overflow", rsp_overflow, m_o);
      end
`ifdef ADD_SUB_ARB_STATS_EN
      check("op_count", op_count, m_ops);
      check("ovf_count", ovf_count, m_ovfs);
`endif
      granted = er;
      if (er != '0) begin
        ia = int'(req_a[g*WIDTH +: WIDTH]);
        ib = int'(req_b[g*WIDTH +: WIDTH]);
        sa = (ia >= (1 << (WIDTH-1))) ? ia - (1 << WIDTH) : ia;
        sb = (ib >= (1 << (WIDTH-1))) ? ib - (1 << WIDTH) : ib;
        if (!req_M[g]) begin
          r = ia + ib; sr = sa + sb; m_c = (r >= (1 << WIDTH)) ? 1 : 0;
        end else begin
          r = ia - ib; sr = sa - sb; m_c = (ia >= ib) ? 1 : 0;
        end
        m_s = ((r % (1 << WIDTH)) + (1 << WIDTH)) % (1 << WIDTH);
        m_o = (sr > (1 << (WIDTH-1)) - 1 || sr < -(1 << (WIDTH-1))) ? 1 : 0;
        m_id = g;
        m_full = 1;
        m_ptr = (g + 1) % NREQ;
        if (m_ops < 16'hFFFF) m_ops++;
        if (m_o == 1 && m_ovfs < 16'hFFFF) m_ovfs++;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_M = '0; req_a = '0; req_b = '0;
    tick;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 0);
    tick;
    rst = 1'b0;

    // round robin from a fresh pointer
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 4'b0001 << (k % 4));
      check("rr_rsp_valid", rsp_valid, (k >= 1) ? 1 : 0);
      tick;
    end

    // add 5+3
    req_valid = 4'b0001; set_op(0, 5, 3, 1'b0);
    @(negedge clk);
    check("add_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("add_valid", rsp_valid, 1);
    check("add_id", rsp_id, 0);
    check("add_s", rsp_s, 8);
    check("add_carry", rsp_carry, 0);
    check("add_ovf", rsp_overflow, 1);

    // subtract 3-5 on requester 2
    tick;
    req_valid = 4'b0100; set_op(2, 3, 5, 1'b1);
    @(negedge clk);
    check("sub_ready", req_ready, 4'b0100);
    tick;
    req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    check("sub_s", rsp_s, 14);
    check("sub_carry", rsp_carry, 0);
    check("sub_ovf", rsp_overflow, 0);
    check("sub_id", rsp_id, 2);

    // backpressure for three cycles
    for (int k = 0; k < 3; k++) begin
      tick;
      req_valid = '1;
      @(negedge clk);
      check("bp_s", rsp_s, 14);
      check("bp_valid", rsp_valid, 1);
      check("bp_ready", req_ready, 0);
    end
    tick;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", req_ready, 4'b1000);
    tick;
    req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", rsp_valid, 1);
    check("pre_rst_id", rsp_id, 3);

    // asynchronous reset while holding a response
    tick;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", rsp_valid, 0);
    tick;
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0110;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0010);
    tick;
    req_valid = '0;

`ifdef ADD_SUB_ARB_STATS_EN
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    req_valid = 4'b0001; set_op(0, 7, 1, 1'b0);
    tick;
    set_op(0, 2, 1, 1'b0);
    tick;
    req_valid = '0;
    @(negedge clk);
    check("stats_ops", op_count, 2);
    check("stats_ovf", ovf_count, 1);
`endif

    // randomized traffic; pending requests held until granted, occasionally withdrawn
    for (int c = 0; c < 3000; c++) begin
      tick;
      rst = ($urandom_range(199) == 0);
      rsp_ready = ($urandom_range(9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !granted[i] && $urandom_range(19) != 0) continue;
        req_valid[i] = 1'($urandom_range(1));
        set_op(i, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)));
      end
    end
    tick;
    rst = 1'b0;
    repeat (3) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
